// File: rtl/capture_crop.sv
// DVP capture stage: assembles 2-byte pixels, crops to a latched window,
// decimates whole frames and emits write strobes with frame/line markers.
module capture_crop #(
  parameter int unsigned H_W   = 11,
  parameter int unsigned V_W   = 10,
  parameter int unsigned DEC_W = 4
) (
  input  logic             i_pclk,
  input  logic             i_rst,
  input  logic             i_vsync,
  input  logic             i_href,
  input  logic [7:0]       i_data,
  input  logic             i_fmt,
  input  logic [H_W-1:0]   i_x0,
  input  logic [H_W-1:0]   i_xlen,
  input  logic [V_W-1:0]   i_y0,
  input  logic [V_W-1:0]   i_ylen,
  input  logic [DEC_W-1:0] i_skip,
  output logic             o_wr,
  output logic [15:0]      o_wdata,
  output logic             o_sof,
  output logic             o_eol,
  output logic             o_eof,
  output logic             o_err
);

  localparam int unsigned HX = H_W + 1;
  localparam int unsigned VX = V_W + 1;

  localparam logic [1:0] ST_SYNC   = 2'd0;
  localparam logic [1:0] ST_VBLANK = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             vsync_q, href_q;
  logic             fmt_q, fmt_d;
  logic [H_W-1:0]   x0_q, x0_d, xlen_q, xlen_d;
  logic [V_W-1:0]   y0_q, y0_d, ylen_q, ylen_d;
  logic             keep_q, keep_d;
  logic [DEC_W-1:0] dec_q, dec_d;
  logic [V_W-1:0]   row_q, row_d;
  logic [H_W-1:0]   col_q, col_d;
  logic             phase_q, phase_d;
  logic [7:0]       hi_q, hi_d;
  logic             wr_q, wr_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d, err_q, err_d;
  logic [15:0]      wdata_q, wdata_d;

  logic [HX-1:0] x_end, col_x;
  logic [VX-1:0] y_end, row_x;
  logic          col_in, row_in;
  logic [15:0]   pix;

  // Window tests are one bit wider than the counters so x0+xlen never wraps.
  assign x_end  = {1'b0, x0_q} + {1'b0, xlen_q};
  assign y_end  = {1'b0, y0_q} + {1'b0, ylen_q};
  assign col_x  = {1'b0, col_q};
  assign row_x  = {1'b0, row_q};
  assign col_in = (col_x >= {1'b0, x0_q}) && (col_x < x_end);
  assign row_in = (row_x >= {1'b0, y0_q}) && (row_x < y_end);
  assign pix    = fmt_q ? {hi_q, i_data} : {4'h0, hi_q[3:0], i_data};

  always_comb begin
    state_d = state_q;
    fmt_d   = fmt_q;
    x0_d    = x0_q;
    xlen_d  = xlen_q;
    y0_d    = y0_q;
    ylen_d  = ylen_q;
    keep_d  = keep_q;
    dec_d   = dec_q;
    row_d   = row_q;
    col_d   = col_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    sof_d   = 1'b0;
    eol_d   = 1'b0;
    eof_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (i_vsync) state_d = ST_VBLANK;
      end
      ST_VBLANK: begin
        // Frame start: snapshot the config so mid-frame changes are ignored.
        if (!i_vsync && vsync_q) begin
          state_d = ST_ACTIVE;
          fmt_d   = i_fmt;
          x0_d    = i_x0;
          xlen_d  = i_xlen;
          y0_d    = i_y0;
          ylen_d  = i_ylen;
          row_d   = '0;
          col_d   = '0;
          phase_d = 1'b0;
          keep_d  = (dec_q == '0);
          sof_d   = (dec_q == '0);
          dec_d   = (dec_q >= i_skip) ? '0 : dec_q + DEC_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (i_vsync && !vsync_q) begin
          state_d = ST_VBLANK;
          eof_d   = keep_q;
        end else if (i_href) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = i_data;
          end else begin
            col_d = (col_q == {H_W{1'b1}}) ? col_q : col_q + H_W'(1);
            if (keep_q && col_in && row_in) begin
              wr_d    = 1'b1;
              wdata_d = pix;
              eol_d   = ((col_x + HX'(1)) == x_end);
            end
          end
        end else if (href_q) begin
          // Row end: a pending high byte is a broken pixel.
          row_d   = (row_q == {V_W{1'b1}}) ? row_q : row_q + V_W'(1);
          col_d   = '0;
          phase_d = 1'b0;
          err_d   = phase_q;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_SYNC;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      fmt_q   <= 1'b0;
      x0_q    <= '0;
      xlen_q  <= '0;
      y0_q    <= '0;
      ylen_q  <= '0;
      keep_q  <= 1'b0;
      dec_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
      wdata_q <= 16'h0000;
      wr_q    <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= i_vsync;
      href_q  <= i_href;
      fmt_q   <= fmt_d;
      x0_q    <= x0_d;
      xlen_q  <= xlen_d;
      y0_q    <= y0_d;
      ylen_q  <= ylen_d;
      keep_q  <= keep_d;
      dec_q   <= dec_d;
      row_q   <= row_d;
      col_q   <= col_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      err_q   <= err_d;
    end
  end

  assign o_wr    = wr_q;
  assign o_wdata = wdata_q;
  assign o_sof   = sof_q;
  assign o_eol   = eol_q;
  assign o_eof   = eof_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_capture_crop.sv
// Scoreboard bench for capture_crop: stimulus tasks push expected output events,
// an independent monitor pops and compares on every DUT output event.
module tb_capture_crop;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        fmt = 1'b0;
  logic [10:0] x0 = '0, xlen = '0;
  logic [9:0]  y0 = '0, ylen = '0;
  logic [3:0]  skip = '0;
  logic        o_wr, o_sof, o_eol, o_eof, o_err;
  logic [15:0] o_wdata;

  capture_crop dut (
    .i_pclk(clk), .i_rst(rst), .i_vsync(vsync), .i_href(href), .i_data(data),
    .i_fmt(fmt), .i_x0(x0), .i_xlen(xlen), .i_y0(y0), .i_ylen(ylen), .i_skip(skip),
    .o_wr(o_wr), .o_wdata(o_wdata), .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Event record: {wr, sof, eof, err, eol, data[15:0]}
  localparam logic [20:0] EV_SOF = 21'h080000;
  localparam logic [20:0] EV_EOF = 21'h040000;
  localparam logic [20:0] EV_ERR = 21'h020000;

  int checks = 0;
  int failures = 0;
  logic [20:0] expq[$];
  logic [20:0] mon_act;
  logic        prev_wr = 1'b0;

  int m_fmt, m_x0, m_xlen, m_y0, m_ylen, m_row, m_dec = 0;
  bit m_keep = 0, m_active = 0;
  int bseq = 0;

  task automatic chk(input string name, input logic [20:0] act, input logic [20:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (o_wr || o_sof || o_eof || o_err || o_eol)) begin
      mon_act = {o_wr, o_sof, o_eof, o_err, o_eol, (o_wr ? o_wdata : 16'h0000)};
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=%h required=none", mon_act);
      end else begin
        chk("output_event", mon_act, expq.pop_front());
      end
      if (o_wr) chk("wr_spacing", 21'(prev_wr), 21'h0);
    end
    prev_wr = o_wr;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      href = 1'b0;
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    vsync = 1'b1;
    href  = 1'b0;
    if (m_active && m_keep) expq.push_back(EV_EOF);
    m_active = 0;
  endtask

  task automatic boundary();
    end_frame();
    repeat (3) @(negedge clk);
    vsync    = 1'b0;
    m_keep   = (m_dec == 0);
    m_dec    = (m_dec >= int'(skip)) ? 0 : m_dec + 1;
    m_fmt    = int'(fmt);
    m_x0     = int'(x0);
    m_xlen   = int'(xlen);
    m_y0     = int'(y0);
    m_ylen   = int'(ylen);
    m_row    = 0;
    m_active = 1;
    if (m_keep) expq.push_back(EV_SOF);
    idle(2);
  endtask

  task automatic send_row(input int nbytes);
    int col;
    logic [7:0] hi, b;
    logic       eol;
    col = 0;
    hi  = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      b = 8'(bseq * 29 + 167);
      bseq++;
      href = 1'b1;
      data = b;
      if (i % 2 == 0) begin
        hi = b;
      end else begin
        if (m_active && m_keep && col >= m_x0 && col < m_x0 + m_xlen &&
            m_row >= m_y0 && m_row < m_y0 + m_ylen) begin
          eol = (col == m_x0 + m_xlen - 1);
          expq.push_back({1'b1, 3'b000, eol, (m_fmt != 0) ? {hi, b} : {4'h0, hi[3:0], b}});
        end
        col++;
      end
    end
    @(negedge clk);
    href = 1'b0;
    if (m_active && (nbytes % 2 == 1)) expq.push_back(EV_ERR);
    if (m_active) m_row++;
    idle(2);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_wr",    21'(o_wr),    21'h0);
    chk("rst_wdata", 21'(o_wdata), 21'h0);
    chk("rst_sof",   21'(o_sof),   21'h0);
    chk("rst_eol",   21'(o_eol),   21'h0);
    chk("rst_eof",   21'(o_eof),   21'h0);
    chk("rst_err",   21'(o_err),   21'h0);
    rst = 1'b0;
    idle(2);

    // RGB444 full window: 8 pixels x 3 rows.
    fmt = 1'b0; x0 = 11'd0; xlen = 11'd8; y0 = 10'd0; ylen = 10'd3; skip = 4'd0;
    boundary();
    repeat (3) send_row(16);

    // RGB565 crop: cols 2..5, rows 1..2.
    fmt = 1'b1; x0 = 11'd2; xlen = 11'd4; y0 = 10'd1; ylen = 10'd2;
    boundary();
    repeat (4) send_row(16);

    // Odd-length row then normal rows.
    fmt = 1'b0; x0 = 11'd0; xlen = 11'd8; y0 = 10'd0; ylen = 10'd4;
    boundary();
    send_row(5);
    send_row(16);
    send_row(16);

    // Empty window still marks the frame.
    xlen = 11'd0;
    boundary();
    send_row(8);

    // Window running past the row end: no eol.
    x0 = 11'd6; xlen = 11'd10; y0 = 10'd0; ylen = 10'd2;
    boundary();
    send_row(16);
    send_row(16);

    // Config change mid-frame applies from the next frame only.
    fmt = 1'b1; x0 = 11'd0; xlen = 11'd4; y0 = 10'd0; ylen = 10'd8;
    boundary();
    send_row(10);
    x0 = 11'd2;
    send_row(10);
    send_row(10);
    boundary();
    send_row(10);

    // Mid-frame reset: outputs clear, rest of frame dropped, no eof.
    send_row(16);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_wr",    21'(o_wr),    21'h0);
    chk("mid_rst_wdata", 21'(o_wdata), 21'h0);
    chk("mid_rst_eol",   21'(o_eol),   21'h0);
    m_active = 0;
    m_dec    = 0;
    idle(2);
    rst = 1'b0;
    send_row(16);
    send_row(16);
    boundary();
    send_row(16);
    send_row(16);

    // Decimation: keep 1 of every 3 frames over 7 frames.
    fmt = 1'b0; x0 = 11'd0; xlen = 11'd8; y0 = 10'd0; ylen = 10'd4; skip = 4'd2;
    for (int f = 0; f < 7; f++) begin
      boundary();
      send_row(8);
    end
    end_frame();
    idle(6);

    chk("queue_drained", 21'(expq.size()), 21'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
